// File: rtl/uart_boot_loader.sv
// UART boot loader: frames received bytes into 32-bit little-endian words,
// writes them to instruction memory and releases the core once the checksum matches.
module uart_boot_loader #(
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W:0]  IDX_ONE  = (ADDR_W + 1)'(1);
  localparam logic [16:0]      MAX_N    = 17'(1) << ADDR_W;

  state_t           state;
  logic             rx_valid_q;
  logic [7:0]       len_lo;
  logic [ADDR_W:0]  len_n;
  logic [ADDR_W:0]  word_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       csum;
  logic [23:0]      word_buf;
  logic [TMO_W-1:0] tmo_cnt;

  logic             stb;
  logic [15:0]      len_full;
  logic             len_bad;
  logic             active;
  logic             tmo_hit;
  logic [ADDR_W:0]  word_idx_nxt;

  always_comb begin
    stb          = rx_valid & ~rx_valid_q;
    len_full     = {rx_byte, len_lo};
    len_bad      = (len_full == 16'd0) || ({1'b0, len_full} > MAX_N);
    active       = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_DATA)   || (state == S_CSUM);
    tmo_hit      = (tmo_cnt == TMO_LAST);
    word_idx_nxt = word_idx + IDX_ONE;
  end

  // Lanes 0..2 of the word under assembly; lane 3 goes straight to mem_wdata.
  always_ff @(posedge clk) begin
    if (state == S_DATA && stb) begin
      case (byte_idx)
        2'd0:    word_buf[7:0]   <= rx_byte;
        2'd1:    word_buf[15:8]  <= rx_byte;
        2'd2:    word_buf[23:16] <= rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rx_valid_q <= 1'b1;
      len_lo     <= '0;
      len_n      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      mem_we     <= 1'b0;

      // Inter-byte watchdog only runs while a frame is in flight.
      if (active) begin
        if (stb) begin
          tmo_cnt <= '0;
        end else if (tmo_hit) begin
          tmo_cnt   <= '0;
          state     <= S_ERR;
          cpu_hold  <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (stb) begin
        case (state)
          S_IDLE: if (rx_byte == SYNC_BYTE) state <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo <= rx_byte;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_bad) begin
              state     <= S_ERR;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b1;
            end else begin
              len_n    <= len_full[ADDR_W:0];
              word_idx <= '0;
              byte_idx <= '0;
              csum     <= '0;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= {rx_byte, word_buf};
              word_idx  <= word_idx_nxt;
              if (word_idx_nxt == len_n) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_byte == csum) begin
              state     <= S_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
              load_err  <= 1'b0;
            end else begin
              state     <= S_ERR;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b1;
            end
          end
          S_DONE: begin
            if (rx_byte == SYNC_BYTE) begin
              state     <= S_LEN_LO;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
            end
          end
          S_ERR: begin
            if (rx_byte == SYNC_BYTE) begin
              state    <= S_LEN_LO;
              load_err <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: good frames, bad checksum, bad length,
// timeout, rx_valid high at reset release and reset mid-frame.
module tb_uart_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int checks;
  int errors;
  int wr_cnt;
  int base;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  uart_boot_loader #(
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = 32'(mem_addr);
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    idle(2);
    rx_valid = 1'b0;
    idle(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},   32'(mem_we),    32'd0);
    chk({tag, "_addr"}, 32'(mem_addr),  32'd0);
    chk({tag, "_wd"},   mem_wdata,      32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold),  32'd1);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"},  32'(load_err),  32'd0);
  endtask

  task automatic check_flags(input string tag, input logic h, input logic d, input logic e);
    chk({tag, "_hold"}, 32'(cpu_hold),  32'(h));
    chk({tag, "_done"}, 32'(load_done), 32'(d));
    chk({tag, "_err"},  32'(load_err),  32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = 8'hA5;
    idle(3);
    check_reset_outputs("rst");

    // rx_valid already high at release: the A5 must not be seen.
    rst_n = 1'b1;
    idle(5);
    rx_valid = 1'b0;
    idle(2);
    base = wr_cnt;
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    send(8'hAD); send(8'hDE); send(8'h22);
    chk("hirel_wr", 32'(wr_cnt - base), 32'd0);
    check_flags("hirel", 1'b1, 1'b0, 1'b0);

    // Single-word good frame.
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t1_hold_pre", 32'(cpu_hold), 32'd1);
    send(8'h22);
    chk("t1_wr",   32'(wr_cnt - base), 32'd1);
    chk("t1_addr", wr_addr[base], 32'd0);
    chk("t1_data", wr_data[base], 32'hDEADBEEF);
    check_flags("t1", 1'b0, 1'b1, 1'b0);

    // Two-word reload from DONE.
    base = wr_cnt;
    send(8'hA5);
    check_flags("t2_reload", 1'b1, 1'b0, 1'b0);
    send(8'h02); send(8'h00);
    for (int i = 0; i < 8; i++) send(8'(i));
    send(8'h00);
    chk("t2_wr",    32'(wr_cnt - base), 32'd2);
    chk("t2_addr0", wr_addr[base],     32'd0);
    chk("t2_data0", wr_data[base],     32'h03020100);
    chk("t2_addr1", wr_addr[base + 1], 32'd1);
    chk("t2_data1", wr_data[base + 1], 32'h07060504);
    check_flags("t2", 1'b0, 1'b1, 1'b0);

    // Bad checksum: word written, frame rejected.
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); send(8'h23);
    chk("t3_wr",   32'(wr_cnt - base), 32'd1);
    chk("t3_data", wr_data[base], 32'hDEADBEEF);
    check_flags("t3", 1'b1, 1'b0, 1'b1);

    // Recovery with a sync byte inside the payload.
    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'hA5);
    chk("t3b_wr",   32'(wr_cnt - base), 32'd1);
    chk("t3b_data", wr_data[base], 32'h000000A5);
    check_flags("t3b", 1'b0, 1'b1, 1'b0);

    // Zero length.
    base = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h00);
    chk("t4a_wr", 32'(wr_cnt - base), 32'd0);
    check_flags("t4a", 1'b1, 1'b0, 1'b1);

    // 1025 words is one too many for ADDR_W=10.
    send(8'hA5);
    chk("t4b_errclr", 32'(load_err), 32'd0);
    send(8'h01); send(8'h04);
    chk("t4b_wr", 32'(wr_cnt - base), 32'd0);
    check_flags("t4b", 1'b1, 1'b0, 1'b1);

    // Timeout mid-data.
    send(8'hA5); send(8'h01); send(8'h00); send(8'hEF);
    chk("t5_pre_err", 32'(load_err), 32'd0);
    base = wr_cnt;
    idle(1500);
    chk("t5_wr", 32'(wr_cnt - base), 32'd0);
    check_flags("t5", 1'b1, 1'b0, 1'b1);

    // Reset mid-DATA discards the frame.
    send(8'hA5); send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs("t6rst");
    rst_n = 1'b1;
    idle(2);
    base = wr_cnt;
    send(8'hAD); send(8'hDE); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); send(8'h22);
    chk("t6_wr", 32'(wr_cnt - base), 32'd0);
    check_flags("t6", 1'b1, 1'b0, 1'b0);

    base = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    chk("t6b_wr",   32'(wr_cnt - base), 32'd1);
    chk("t6b_data", wr_data[base], 32'h44332211);
    check_flags("t6b", 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
